// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment display.
package display_pkg;

  typedef enum logic [1:0] {
    StBlankU = 2'd0,
    StUni    = 2'd1,
    StBlankD = 2'd2,
    StDec    = 2'd3
  } disp_state_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic digit_ok(input logic [7:0] digit);
    return digit <= 8'd9;
  endfunction

endpackage

// File: rtl/display_mux_if.sv
// Digit inputs and display outputs of display_mux, bundled with master/slave views.
interface display_mux_if;
  logic [7:0] unidades;
  logic [7:0] decenas;
  logic       update;
  logic [6:0] segmentos;
  logic [1:0] anodos;
  logic       fuera_rango;

  modport master (
    output unidades, decenas, update,
    input  segmentos, anodos, fuera_rango
  );

  modport slave (
    input  unidades, decenas, update,
    output segmentos, anodos, fuera_rango
  );
endinterface

// File: rtl/seg_decoder.sv
// Combinational BCD digit to seven-segment pattern; anything above 9 shows a dash.
module seg_decoder
  import display_pkg::*;
(
  input  logic [7:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      8'd0:    o_seg = SEG_0;
      8'd1:    o_seg = SEG_1;
      8'd2:    o_seg = SEG_2;
      8'd3:    o_seg = SEG_3;
      8'd4:    o_seg = SEG_4;
      8'd5:    o_seg = SEG_5;
      8'd6:    o_seg = SEG_6;
      8'd7:    o_seg = SEG_7;
      8'd8:    o_seg = SEG_8;
      8'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps, edge-triggered
// digit capture, leading-zero suppression on the tens digit and an out-of-range flag.
module display_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  display_mux_if.slave  bus
);

  localparam int unsigned MaxDur = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxDur + 1);
  localparam logic [CntW-1:0] LitLast   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  disp_state_e     r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_uni, r_dec;
  logic            r_update_d;
  logic            r_rst_d;
  logic            w_capture;
  logic [7:0]      w_digit;
  logic [6:0]      w_seg;
  logic [1:0]      w_anodos_d;
  logic [6:0]      w_segmentos_d;
  logic [1:0]      r_anodos;
  logic [6:0]      r_segmentos;
  logic            r_fuera;

  // The cycle right after reset is masked so a level already high at release is not an edge.
  assign w_capture = bus.update & ~r_update_d & ~r_rst_d;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    unique case (r_state)
      StBlankU: if (r_cnt == BlankLast) begin
        w_state_d = StUni;
        w_cnt_d   = '0;
      end
      StUni: if (r_cnt == LitLast) begin
        w_state_d = StBlankD;
        w_cnt_d   = '0;
      end
      StBlankD: if (r_cnt == BlankLast) begin
        w_state_d = StDec;
        w_cnt_d   = '0;
      end
      StDec: if (r_cnt == LitLast) begin
        w_state_d = StBlankU;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so registered anodos line up with r_state, but use the
  // current shadow digits so a capture shows one edge later.
  assign w_digit = (w_state_d == StDec) ? r_dec : r_uni;

  seg_decoder u_seg_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  always_comb begin
    w_anodos_d    = 2'b00;
    w_segmentos_d = SEG_OFF;
    unique case (w_state_d)
      StUni: begin
        w_anodos_d    = 2'b01;
        w_segmentos_d = w_seg;
      end
      StDec: if (r_dec != 8'd0) begin
        w_anodos_d    = 2'b10;
        w_segmentos_d = w_seg;
      end
      StBlankU, StBlankD: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StBlankU;
      r_cnt       <= '0;
      r_uni       <= 8'd0;
      r_dec       <= 8'd0;
      r_update_d  <= 1'b0;
      r_rst_d     <= 1'b1;
      r_anodos    <= 2'b00;
      r_segmentos <= SEG_OFF;
      r_fuera     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_update_d  <= bus.update;
      r_rst_d     <= 1'b0;
      r_anodos    <= w_anodos_d;
      r_segmentos <= w_segmentos_d;
      r_fuera     <= ~digit_ok(r_uni) | ~digit_ok(r_dec);
      if (w_capture) begin
        r_uni <= bus.unidades;
        r_dec <= bus.decenas;
      end
    end
  end

  assign bus.anodos      = r_anodos;
  assign bus.segmentos   = r_segmentos;
  assign bus.fuera_rango = r_fuera;

endmodule

// File: tb/tb_display_mux.sv
// Directed plus random checks of display_mux against a slot-position reference model.
module tb_display_mux;

  localparam int unsigned RD  = 8;
  localparam int unsigned BC  = 2;
  localparam int unsigned PER = 2 * (RD + BC);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Reference state: position in the refresh period and the captured digits.
  int         m_phase;
  logic [7:0] m_u, m_d;
  logic       m_prev_upd;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  display_mux_if bus ();

  display_mux #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pattern(input logic [7:0] v);
    if (v < 8'd10) return seg_tab[v];
    return 7'h40;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h phase=%0d", tag, obs, exp, m_phase);
    end
  endtask

  // One clock: sample inputs as seen at the edge, advance the model, compare #1 after the edge.
  task automatic step();
    logic       rst_s, upd_s;
    logic [7:0] u_s, d_s;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    logic       e_fr;
    int         pos;
    rst_s = reset;
    upd_s = bus.update;
    u_s   = bus.unidades;
    d_s   = bus.decenas;
    @(posedge clk);
    #1;
    e_an  = 2'b00;
    e_seg = 7'h00;
    e_fr  = 1'b0;
    if (rst_s) begin
      m_phase    = 0;
      m_u        = 8'd0;
      m_d        = 8'd0;
      m_prev_upd = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % PER;
      pos     = m_phase;
      e_fr    = (m_u > 8'd9) || (m_d > 8'd9);
      if (pos >= BC && pos < BC + RD) begin
        e_an  = 2'b01;
        e_seg = pattern(m_u);
      end else if (pos >= 2 * BC + RD && m_d != 8'd0) begin
        e_an  = 2'b10;
        e_seg = pattern(m_d);
      end
      if (upd_s && !m_prev_upd) begin
        m_u = u_s;
        m_d = d_s;
      end
      m_prev_upd = upd_s;
    end
    chk("anodos", {6'd0, bus.anodos}, {6'd0, e_an});
    chk("segmentos", {1'b0, bus.segmentos}, {1'b0, e_seg});
    chk("fuera_rango", {7'd0, bus.fuera_rango}, {7'd0, e_fr});
    chk("anodos_not_both", {7'd0, (bus.anodos == 2'b11)}, 8'd0);
    chk("dark_when_off", {7'd0, (bus.anodos == 2'b00 && bus.segmentos != 7'h00)}, 8'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic capture(input logic [7:0] u, input logic [7:0] d);
    bus.unidades = u;
    bus.decenas  = d;
    bus.update   = 1'b1;
    step();
    bus.update   = 1'b0;
  endtask

  initial begin
    m_phase       = 0;
    m_u           = 8'd0;
    m_d           = 8'd0;
    m_prev_upd    = 1'b1;
    bus.unidades  = 8'd0;
    bus.decenas   = 8'd0;
    bus.update    = 1'b0;

    // Reset, then free-running with nothing captured: units 0, tens blanked.
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2 * PER);

    // Plain capture of 45.
    capture(8'd5, 8'd4);
    run(PER + 5);

    // Held update: only the first edge captures, later input changes ignored.
    bus.unidades = 8'd5;
    bus.decenas  = 8'd4;
    bus.update   = 1'b1;
    step();
    bus.unidades = 8'd2;
    bus.decenas  = 8'd7;
    run(49);
    bus.update   = 1'b0;
    run(PER);

    // Out-of-range tens digit.
    capture(8'd3, 8'd12);
    run(PER + 3);

    // Capture mid units slot.
    for (int i = 0; i < PER && m_phase != BC + 3; i++) step();
    capture(8'd9, 8'd9);
    run(PER);

    // Reset mid tens slot while update is held high through release.
    for (int i = 0; i < PER && m_phase != 2 * BC + RD + 3; i++) step();
    bus.unidades = 8'd8;
    bus.decenas  = 8'd6;
    bus.update   = 1'b1;
    reset        = 1'b1;
    run(2);
    reset        = 1'b0;
    run(PER + 4);
    bus.update   = 1'b0;
    step();
    capture(8'd1, 8'd6);
    run(PER);

    // Random traffic, including out-of-range digits and input changes while update is high.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.update = ~bus.update;
      if ($urandom_range(0, 3) == 0) bus.unidades = 8'($urandom_range(0, 13));
      if ($urandom_range(0, 3) == 0) bus.decenas  = 8'($urandom_range(0, 13));
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, number of clock cycles each digit is lit (must be >=1).
REQ-002 Parameter: BLANK_CYCLES, default 4, number of all-off clock cycles between digit slots to prevent ghosting (must be >=1).
REQ-003 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: unidades  input  8  units digit from the number separator stage; valid range 0..9.
REQ-006 Port: decenas  input  8  tens digit from the number separator stage; valid range 0..9.
REQ-007 Port: update  input  1  level signal; its rising edge, sampled on clk, commands a capture of unidades/decenas.
REQ-008 Port: segmentos  output  7  {g,f,e,d,c,b,a}, active-high (1 = segment lit).
REQ-009 Port: anodos  output  2  one-hot, active-high digit enable; bit0 = units, bit1 = tens.
REQ-010 Port: fuera_rango  output  1  high while either captured digit is greater than 9.

Function
REQ-011 The block SHALL register update into update_d and detect a capture edge as update AND NOT update_d.
REQ-012 On a capture edge at clock edge k, the block SHALL load both digits into shadow registers at edge k; the display reflects the new values from edge k+1 onward.
REQ-013 Holding update high SHALL produce exactly one capture; the inputs are ignored at all other times.
REQ-014 The FSM SHALL have states BLANK_U, UNI, BLANK_D, DEC, cycling in that order: BLANK_U->UNI->BLANK_D->DEC->BLANK_U.
REQ-015 A single counter SHALL time each state: UNI and DEC last REFRESH_DIV cycles, BLANK_U and BLANK_D last BLANK_CYCLES cycles; the counter clears on every state transition.
REQ-016 The counter width SHALL be clog2 of max(REFRESH_DIV, BLANK_CYCLES)+1; the counter SHALL never wrap inside a state.
REQ-017 One full refresh period SHALL be 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-018 In BLANK_U/BLANK_D the outputs SHALL be anodos=00 and segmentos=0000000.
REQ-019 In UNI the outputs SHALL be anodos=01 and segmentos=the decoded units digit.
REQ-020 In DEC the outputs SHALL be anodos=10 and segmentos=the decoded tens digit, except that a tens value of 0 SHALL give anodos=00, segmentos=0 (leading-zero blanking).
REQ-021 Decoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, g..a); any value >9 SHALL decode to 40 (dash).
REQ-022 fuera_rango SHALL be registered from the shadow registers and be valid one cycle after capture.
REQ-023 A capture SHALL NOT reset or stretch the FSM timing; a capture during a lit slot changes segmentos mid-slot at edge k+1.
REQ-024 All outputs SHALL be registered; anodos SHALL never have both bits high.

Reset
REQ-025 While reset is high at a clock edge: state=BLANK_U, counter=0, shadow digits=0, update_d=0, anodos=00, segmentos=0000000, fuera_rango=0.
REQ-026 Reset asserted mid-slot SHALL abort the slot at that edge; after release the first lit slot (UNI) begins BLANK_CYCLES cycles later.
REQ-027 An update already high when reset is released SHALL NOT be captured until it goes low and rises again.

Structure
REQ-028 A shared package display_pkg SHALL hold the FSM state enum, the ten segment constants and the SEG_DASH/SEG_OFF constants.
REQ-029 A sub-module seg_decoder (8-bit digit in, 7-bit pattern out, combinational) SHALL implement REQ-021 and be instantiated once, fed by a state-selected digit.

Verification (bench: REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset, then no update -> anodos 00 for 2 cycles, 01 with segmentos=3F for 8, 00 for 2, 00 (tens blank) for 8; period 20 cycles.
REQ-031 Capture decenas=4, unidades=5 -> UNI slots show 6D on anodos=01, DEC slots show 66 on anodos=10.
REQ-032 Hold update high for 50 cycles while changing inputs 4/5 -> 7/2 after the first edge -> display stays 45; no second capture.
REQ-033 Capture decenas=12, unidades=3 -> fuera_rango=1 one cycle later; DEC slot segmentos=40, UNI slot=4F.
REQ-034 Capture 9/9 mid-UNI slot -> segmentos switches to 6F at edge k+1 with no change in slot length; assert reset mid-DEC -> all outputs zero next edge, shadow=0.
REQ-035 Continuous check across all tests: anodos never 11; segmentos=0 whenever anodos=00.
